clock_run_sequencer: RTL



---
 rtl/clock_ctrl_pkg.sv | 28 ++
 rtl/clock_run_sequencer_if.sv | 29 ++
 rtl/clock_run_sequencer_sync_debounce.sv | 57 +++++
 rtl/clock_run_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_ctrl_pkg
// Brief    : Shared state encoding, default timing constants and a counter
//            width helper for the E100 clock run sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD_RST  = 3'd1,
        HALT      = 3'd2,
        RUN       = 3'd3,
        STEP      = 3'd4
    } state_t;

    localparam int c_VALID_STABLE_CYCLES_DEF = 1024;
    localparam int c_RESET_HOLD_CYCLES_DEF   = 16;
    localparam int c_DEBOUNCE_CYCLES_DEF     = 100000;

    // Width of a counter covering 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_run_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_run_sequencer_if
// Brief    : Board/CPU-side signal bundle of the clock run sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface clock_run_sequencer_if;

    logic        clock_valid;
    logic        run_switch;
    logic        step_button;
    logic        halt_request;
    logic        cpu_reset;
    logic        cpu_enable;
    logic        running;
    logic [31:0] enabled_cycles;

    modport master (
        output clock_valid, run_switch, step_button, halt_request,
        input  cpu_reset, cpu_enable, running, enabled_cycles
    );

    modport slave (
        input  clock_valid, run_switch, step_button, halt_request,
        output cpu_reset, cpu_enable, running, enabled_cycles
    );

endinterface
`default_nettype wire

// File: rtl/clock_run_sequencer_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sync_debounce
// Brief    : Two-flop synchronizer plus debouncer; reports the accepted level
//            and a one-cycle pulse on the accepted 0->1 change.
// Revision : 1.0 - initial release
// ============================================================================
module sync_debounce
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_async,
    output logic      o_level,
    output logic      o_rise
);

    localparam int                c_CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_accept;

    // The change is accepted in the cycle that completes the stable run, so
    // the rise pulse is combinational and lines up with the level update.
    assign w_accept = (r_sync != r_level) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = w_accept & r_sync;

endmodule
`default_nettype wire

// File: rtl/clock_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : clock_run_sequencer
// Brief    : Waits for PLL lock, holds then releases CPU reset, and schedules
//            CPU clock enables in run / halt / single-step modes.
// Revision : 1.0 - initial release
// ============================================================================
module clock_run_sequencer
    import clock_ctrl_pkg::*;
#(
    parameter int VALID_STABLE_CYCLES = c_VALID_STABLE_CYCLES_DEF,
    parameter int RESET_HOLD_CYCLES   = c_RESET_HOLD_CYCLES_DEF,
    parameter int DEBOUNCE_CYCLES     = c_DEBOUNCE_CYCLES_DEF
) (
    input  wire logic            clock,
    input  wire logic            reset,
    clock_run_sequencer_if.slave bus
);

    localparam int                  c_LOCK_W    = cnt_width(VALID_STABLE_CYCLES);
    localparam int                  c_HOLD_W    = cnt_width(RESET_HOLD_CYCLES);
    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(VALID_STABLE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RESET_HOLD_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_valid_meta;
    logic                r_valid_sync;
    logic                r_run_meta;
    logic                r_run_sync;
    logic [c_LOCK_W-1:0] r_lock_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_cpu_reset;
    logic                r_cpu_enable;
    logic                r_running;
    logic [31:0]         r_enabled_cycles;
    logic                w_step_level;
    logic                w_step_rise;
    logic                w_step_pulse;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clock   (clock),
        .reset   (reset),
        .i_async (bus.step_button),
        .o_level (w_step_level),
        .o_rise  (w_step_rise)
    );

    // A rise is only ever reported while the accepted level is still low.
    assign w_step_pulse = w_step_rise & ~w_step_level;

    always_comb begin
        w_next = r_state;
        if (!r_valid_sync) begin
            w_next = WAIT_LOCK;
        end else begin
            case (r_state)
                WAIT_LOCK: if (r_lock_cnt == c_LOCK_LAST) w_next = HOLD_RST;
                HOLD_RST:  if (r_hold_cnt == c_HOLD_LAST) w_next = HALT;
                HALT: begin
                    if (r_run_sync && !bus.halt_request) w_next = RUN;
                    else if (w_step_pulse)               w_next = STEP;
                end
                RUN:       if (!r_run_sync || bus.halt_request) w_next = HALT;
                STEP:      w_next = HALT;
                default:   w_next = WAIT_LOCK;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= WAIT_LOCK;
            r_valid_meta     <= 1'b0;
            r_valid_sync     <= 1'b0;
            r_run_meta       <= 1'b0;
            r_run_sync       <= 1'b0;
            r_lock_cnt       <= '0;
            r_hold_cnt       <= '0;
            r_cpu_reset      <= 1'b1;
            r_cpu_enable     <= 1'b0;
            r_running        <= 1'b0;
            r_enabled_cycles <= '0;
        end else begin
            r_valid_meta <= bus.clock_valid;
            r_valid_sync <= r_valid_meta;
            r_run_meta   <= bus.run_switch;
            r_run_sync   <= r_run_meta;
            r_state      <= w_next;

            r_lock_cnt <= (r_state == WAIT_LOCK && w_next == WAIT_LOCK && r_valid_sync)
                          ? r_lock_cnt + 1'b1 : '0;
            r_hold_cnt <= (r_state == HOLD_RST && w_next == HOLD_RST)
                          ? r_hold_cnt + 1'b1 : '0;

            // The count survives lock loss; only a fresh reset hold clears it.
            if (r_state == HOLD_RST)
                r_enabled_cycles <= '0;
            else if (r_cpu_enable)
                r_enabled_cycles <= r_enabled_cycles + 32'd1;

            r_cpu_reset  <= (w_next == WAIT_LOCK) || (w_next == HOLD_RST);
            r_cpu_enable <= (w_next == RUN) || (w_next == STEP);
            r_running    <= (w_next == RUN);
        end
    end

    assign bus.cpu_reset      = r_cpu_reset;
    assign bus.cpu_enable     = r_cpu_enable;
    assign bus.running        = r_running;
    assign bus.enabled_cycles = r_enabled_cycles;

endmodule
`default_nettype wire
